// File: rtl/brique_event_ctrl_if.sv
// brique_event_ctrl_if
//   Avalon-MM slave bus (read latency 1) plus the level interrupt that the
//   Nios uses to service the brick event controller.
//
//   address   [1:0]  word address
//   read             read strobe
//   write            write strobe
//   writedata [31:0] write data
//   readdata  [31:0] read data, registered, valid the cycle after read
//   irq              level interrupt, active-high
//
//   Modports: master = Nios side, slave = controller side.
interface brique_event_ctrl_if;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (output address, read, write, writedata, input readdata, irq);
  modport slave  (input address, read, write, writedata, output readdata, irq);
endinterface

// File: rtl/brique_event_ctrl.sv
// brique_event_ctrl
//   Queues brick-destruction events in a FIFO, keeps a saturating kill
//   counter and exposes both to the Nios over an Avalon-MM slave.
//
//   Parameters: IDX_W brick index width, DEPTH FIFO depth (power of two).
//   Ports:
//     clk         system clock
//     reset       synchronous, active-high reset
//     kill_valid  one-cycle event pulse
//     kill_idx    index of the destroyed brick
//     bus         Avalon slave + irq (brique_event_ctrl_if.slave)
//
//   Register map: 0 DATA (read pops), 1 STATUS, 2 IRQ_MASK, 3 KILL_COUNT.
//
//   Optional feature: define BRIQUE_EVT_DEDUP_EN to ignore repeated kills of
//   an index until KILL_COUNT is written.
//
//   Handshake: kill_valid has no ready; every pulse is taken in the cycle it
//   is presented (queued, or dropped with overflow when the FIFO is full and
//   no pop happens in that cycle). An Avalon read is accepted whenever read is
//   high and its data appears on readdata one cycle later.
module brique_event_ctrl #(
  parameter int IDX_W = 6,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             kill_valid,
  input  logic [IDX_W-1:0] kill_idx,
  brique_event_ctrl_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [IDX_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic             overflow;
  logic [1:0]       mask;
  logic [15:0]      count;
  logic [31:0]      readdata_q;
  logic [31:0]      rd_mux;

  logic empty, full, pop, evt, push, drop;
  logic wr_status, wr_mask, wr_count;
  logic unused_wdata;

  assign empty = (level == '0);
  assign full  = (level == FULL_LVL);

  assign pop       = bus.read  && (bus.address == 2'd0) && !empty;
  assign wr_status = bus.write && (bus.address == 2'd1);
  assign wr_mask   = bus.write && (bus.address == 2'd2);
  assign wr_count  = bus.write && (bus.address == 2'd3);

  assign unused_wdata = ^{bus.writedata[31:17], bus.writedata[15:2]};

`ifdef BRIQUE_EVT_DEDUP_EN
  // One bit per possible brick; a kill on an already-marked brick is ignored.
  logic [(2**IDX_W)-1:0] killed;
  logic                  dup;

  assign dup = killed[kill_idx];
  assign evt = kill_valid && !dup;

  // The bit is marked even when the event is dropped on overflow.
  always_ff @(posedge clk) begin
    if (reset || wr_count) killed <= '0;
    else if (evt)          killed[kill_idx] <= 1'b1;
  end
`else
  assign evt = kill_valid;
`endif

  // A same-cycle pop frees the slot the push needs, so a full FIFO still
  // accepts the event.
  assign push = evt && (!full || pop);
  assign drop = evt && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= kill_idx;
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      2'd0: begin
        if (!empty) begin
          rd_mux[31]        = 1'b1;
          rd_mux[IDX_W-1:0] = mem[rd_ptr];
        end
      end
      2'd1: begin
        rd_mux[0]          = empty;
        rd_mux[1]          = full;
        rd_mux[8 +: LVL_W] = level;
        rd_mux[16]         = overflow;
      end
      2'd2:    rd_mux[1:0]  = mask;
      default: rd_mux[15:0] = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      mask       <= 2'b00;
      count      <= 16'h0000;
      readdata_q <= 32'h0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase

      // A new drop wins over a clear in the same cycle so it is not lost.
      if (drop)                             overflow <= 1'b1;
      else if (wr_status && bus.writedata[16]) overflow <= 1'b0;

      if (wr_mask) mask <= bus.writedata[1:0];

      if (wr_count)                          count <= 16'h0000;
      else if (evt && (count != 16'hFFFF))   count <= count + 16'd1;

      if (bus.read) readdata_q <= rd_mux;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = (mask[0] && !empty) || (mask[1] && overflow);

endmodule

// File: tb/tb_brique_event_ctrl.sv
// tb_brique_event_ctrl
//   Directed bench for brique_event_ctrl (IDX_W=6, DEPTH=8). Every read
//   pushes its expected readdata into exp_q; a monitor pops and compares on
//   the cycle the registered data appears.
module tb_brique_event_ctrl;

  localparam int IDX_W = 6;
  localparam int DEPTH = 8;

  logic             clk;
  logic             reset;
  logic             kill_valid;
  logic [IDX_W-1:0] kill_idx;

  brique_event_ctrl_if bus ();

  brique_event_ctrl #(.IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .kill_valid (kill_valid),
    .kill_idx   (kill_idx),
    .bus        (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q [$];
  string       name_q [$];
  int          n_pass  = 0;
  int          n_total = 0;
  logic        rd_d;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endfunction

  always @(posedge clk) rd_d <= bus.read;

  // Monitor: readdata is valid the cycle after a sampled read.
  always @(negedge clk) begin
    if (rd_d === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_read", bus.readdata, 32'hDEAD_BEEF);
      end else begin
        check(name_q.pop_front(), bus.readdata, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic avm_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    bus.address = a;
    bus.read    = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(posedge clk); #1;
    bus.read = 1'b0;
  endtask

  task automatic avm_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address   = a;
    bus.writedata = d;
    bus.write     = 1'b1;
    @(posedge clk); #1;
    bus.write = 1'b0;
  endtask

  task automatic kill(input logic [IDX_W-1:0] idx);
    @(negedge clk);
    kill_valid = 1'b1;
    kill_idx   = idx;
    @(posedge clk); #1;
    kill_valid = 1'b0;
  endtask

  // Kill and DATA read presented in the same cycle.
  task automatic kill_and_pop(input logic [IDX_W-1:0] idx, input logic [31:0] exp, input string name);
    @(negedge clk);
    kill_valid  = 1'b1;
    kill_idx    = idx;
    bus.address = 2'd0;
    bus.read    = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(posedge clk); #1;
    kill_valid = 1'b0;
    bus.read   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset         = 1'b1;
    kill_valid    = 1'b0;
    kill_idx      = '0;
    bus.address   = 2'd0;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.writedata = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("reset_irq", {31'h0, bus.irq}, 32'h0);
    check("reset_readdata", bus.readdata, 32'h0);
    avm_read(2'd1, 32'h0000_0001, "reset_status");
    avm_read(2'd3, 32'h0000_0000, "reset_count");

    // Basic queue + irq
    avm_write(2'd2, 32'h1);
    kill(6'd5);
    check("irq_after_first_kill", {31'h0, bus.irq}, 32'h1);
    kill(6'd9);
    kill(6'd12);
    avm_read(2'd3, 32'h0000_0003, "count_3");
    avm_read(2'd0, 32'h8000_0005, "data_5");
    avm_read(2'd0, 32'h8000_0009, "data_9");
    check("irq_before_drain", {31'h0, bus.irq}, 32'h1);
    avm_read(2'd0, 32'h8000_000C, "data_12");
    check("irq_after_drain", {31'h0, bus.irq}, 32'h0);
    avm_read(2'd0, 32'h0000_0000, "data_empty");

    // Overflow: DEPTH+2 kills, overflow interrupt only
    do_reset();
    avm_write(2'd2, 32'h2);
    for (int i = 0; i < DEPTH + 2; i++) kill(6'(20 + i));
    check("irq_overflow", {31'h0, bus.irq}, 32'h1);
    avm_read(2'd1, 32'h0001_0802, "status_overflow");
    avm_read(2'd3, 32'h0000_000A, "count_depth_plus_2");
    avm_write(2'd1, 32'h0001_0000);
    check("irq_overflow_cleared", {31'h0, bus.irq}, 32'h0);
    avm_read(2'd1, 32'h0000_0802, "status_ovf_cleared");

    // Full FIFO: kill + pop in the same cycle
    kill_and_pop(6'd40, 32'h8000_0014, "pop_while_push");
    avm_read(2'd1, 32'h0000_0802, "status_push_pop_full");
    for (int i = 1; i < DEPTH; i++) avm_read(2'd0, 32'h8000_0014 + 32'(i), "drain_full");
    avm_read(2'd0, 32'h8000_0028, "data_last_40");
    avm_read(2'd0, 32'h0000_0000, "data_empty_after_full");

`ifndef BRIQUE_EVT_DEDUP_EN
    // Count saturation with kill_valid held for 0x10000 cycles
    do_reset();
    @(negedge clk);
    kill_valid = 1'b1;
    repeat (65536) begin
      kill_idx = kill_idx + 6'd1;
      @(negedge clk);
    end
    kill_valid = 1'b0;
    avm_read(2'd3, 32'h0000_FFFF, "count_saturated");
    avm_write(2'd3, 32'h1234_5678);
    avm_read(2'd3, 32'h0000_0000, "count_cleared");
`endif

    // Repeated index
    do_reset();
    kill(6'd7);
    kill(6'd7);
`ifdef BRIQUE_EVT_DEDUP_EN
    avm_read(2'd3, 32'h0000_0001, "dup_count");
    avm_read(2'd0, 32'h8000_0007, "dup_data0");
    avm_read(2'd0, 32'h0000_0000, "dup_data1");
    avm_write(2'd3, 32'h0);
    kill(6'd7);
    avm_read(2'd0, 32'h8000_0007, "dup_after_clear");
    avm_read(2'd3, 32'h0000_0001, "dup_count_after_clear");
`else
    avm_read(2'd3, 32'h0000_0002, "dup_count");
    avm_read(2'd0, 32'h8000_0007, "dup_data0");
    avm_read(2'd0, 32'h8000_0007, "dup_data1");
    avm_read(2'd0, 32'h0000_0000, "dup_data2");
`endif

    // Reset mid-operation with 4 entries queued
    do_reset();
    avm_write(2'd2, 32'h1);
    for (int i = 0; i < 4; i++) kill(6'(50 + i));
    avm_read(2'd1, 32'h0000_0400, "status_level4");
    @(negedge clk);
    check("irq_before_reset", {31'h0, bus.irq}, 32'h1);
    do_reset();
    check("midreset_irq", {31'h0, bus.irq}, 32'h0);
    check("midreset_readdata", bus.readdata, 32'h0);
    avm_read(2'd1, 32'h0000_0001, "midreset_status");
    avm_read(2'd3, 32'h0000_0000, "midreset_count");

    repeat (3) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/brique_event_ctrl.md
# brique_event_ctrl

Brick-destruction event controller for the Nios ball subsystem. Collision logic reports each destroyed brick as a one-cycle pulse with its brick index. The block queues these events in a small FIFO and keeps a saturating kill counter. The Nios drains the queue over an Avalon-MM slave with read latency 1, and an interrupt replaces polling of a single brick-dead status bit.

## Interface
Parameters:
- IDX_W, 6, brick index width (up to 64 bricks); 1..16
- DEPTH, 8, FIFO depth in entries; power of two, 2..64

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- kill_valid  in  1  one-cycle pulse: brick kill_idx destroyed
- kill_idx  in  IDX_W  index of destroyed brick, valid with kill_valid
- address  in  2  Avalon word address
- read  in  1  Avalon read strobe
- write  in  1  Avalon write strobe
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, registered
- irq  out  1  interrupt request, level, active-high

## Operation
Register map:
- addr 0, DATA (RO):
  - Read with FIFO non-empty returns {bit31=1, bits[IDX_W-1:0]=head idx} and pops the head.
  - Read with FIFO empty returns 0 and does not pop.
- addr 1, STATUS (R/W):
  - Read: bit0 empty, bit1 full, bit16 overflow (sticky), bits[14:8] level.
  - Write with writedata[16]=1 clears overflow; other bits are ignored.
- addr 2, IRQ_MASK (R/W):
  - bit0 enables the non-empty interrupt source; bit1 enables the overflow interrupt source.
- addr 3, KILL_COUNT (R/W):
  - Read returns a 16-bit count, saturating at 0xFFFF.
  - Any write clears the count.
- Unused readdata bits are 0.

Push and pop rules:
- Push: kill_valid=1 and FIFO not full → kill_idx enqueued and level+1. The count increments in either case (full or not full).
- Push while full → event dropped, overflow set, level unchanged.
- Push and pop in the same cycle → level unchanged, both take effect. A push on a full FIFO is accepted if a pop occurs in the same cycle, and overflow is not set.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Level is log2(DEPTH)+1 bits; full means level==DEPTH.
- irq = (mask[0] & ~empty) | (mask[1] & overflow), decoded from registered state.
- A write and a read in the same cycle are illegal (Avalon); behaviour is undefined.
- Writes to addr 0 are ignored.

Reset values:
- readdata=0 and irq=0.
- FIFO empty, pointers=0, level=0.
- overflow=0, mask=0, count=0.
- Dedup bitmap cleared, if compiled in.

Reset mid-operation discards all queued events and the count.

## Timing
- kill_valid sampled at edge N → empty=0 from after N, so irq (if mask[0]) is high in cycle N+1.
- Avalon read sampled at edge M → readdata valid after M (latency 1). readdata holds its value until the next read.
- A pop takes effect at edge M. A back-to-back DATA read at M+1 returns the next entry.
- irq deasserts the cycle after the pop that empties the FIFO (mask[0] source).
- IRQ_MASK, STATUS and KILL_COUNT writes take effect at the sampling edge. irq reflects a mask write from the following cycle.
- Count saturation: an event at count=0xFFFF leaves the count at 0xFFFF.

## Configuration
- Macro BRIQUE_EVT_DEDUP_EN.
- Defined:
  - A 2^IDX_W-bit killed bitmap records every accepted index.
  - kill_valid on an index whose bit is already set is ignored entirely: no enqueue, no count change, no overflow.
  - A KILL_COUNT write clears the bitmap together with the count (new level).
  - The bitmap bit is set even when the event overflows.
- Undefined:
  - No bitmap.
  - Every kill_valid is processed as a push and counted.

## Test plan
- Reset, then 3 pulses idx 5, 9, 12 with mask=1 → irq high the cycle after the first pulse. DATA reads return 0x80000005, 0x80000009, 0x8000000C, then 0. irq low the cycle after the third read.
- DEPTH+2 pulses with no reads → STATUS full=1, overflow=1, level=DEPTH, count=DEPTH+2. Writing 0x10000 to STATUS clears overflow only.
- FIFO full, kill_valid and a DATA read in the same cycle → no overflow, level stays DEPTH, the new idx is last out.
- 0x10000 events with no reads → count saturates at 0xFFFF. Any write to addr 3 → count 0.
- With BRIQUE_EVT_DEDUP_EN: idx 7 pulsed twice → one entry, count=1. After a write to addr 3, idx 7 is accepted again. Without the macro → two entries, count=2.
- Synchronous reset asserted with 4 entries queued → the next cycle shows empty=1, irq=0, readdata=0, count=0.
